// File: rtl/burst_ack_responder.sv
// burst_ack_responder
// Responder half of a req/ack repetition handshake. A rising edge on req
// (with window high) starts a burst of COUNT single-cycle ack pulses.
// Consecutive pulses are separated by a gap latched at burst start.
// If window falls before the burst completes, the burst aborts.
// Every output comes straight from a flop.

module burst_ack_responder #(
    parameter int COUNT = 3,
    parameter int GAP_W = 4,
    parameter int CNT_W = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             window,
    input  logic [GAP_W-1:0] gap,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic [CNT_W-1:0] ack_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PULSE = 3'd1,
        ST_GAP   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

    state_t             state_r;
    state_t             state_s;
    logic               req_q_r;
    logic               rise_s;
    logic [GAP_W-1:0]   gap_l_r;
    logic [GAP_W-1:0]   gap_l_s;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_s;
    logic [CNT_W-1:0]   ack_cnt_r;
    logic [CNT_W-1:0]   ack_cnt_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               ack_r;
    logic               busy_r;
    logic               done_r;
    logic               abort_r;

    assign rise_s  = req & ~req_q_r;
    assign ack     = ack_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign abort   = abort_r;
    assign ack_cnt = ack_cnt_r;

    // Next-state, counter and gap-latch logic for the burst sequencer.
    always_comb begin
        state_s   = state_r;
        gap_l_s   = gap_l_r;
        gap_cnt_s = gap_cnt_r;
        ack_cnt_s = ack_cnt_r;

        // The ack count saturates at COUNT so a stray extra pulse cannot wrap it.
        if (ack_cnt_r == COUNT_C) begin
            cnt_inc_s = ack_cnt_r;
        end else begin
            cnt_inc_s = ack_cnt_r + CNT_W'(1);
        end

        case (state_r)
            ST_IDLE: begin
                // A rise while window is low is ignored without raising abort.
                if (rise_s && window) begin
                    state_s   = ST_PULSE;
                    gap_l_s   = gap;
                    ack_cnt_s = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                // The ack just driven is counted even if this edge aborts.
                ack_cnt_s = cnt_inc_s;
                if (!window) begin
                    state_s = ST_ABORT;
                end else if (cnt_inc_s == COUNT_C) begin
                    state_s = ST_DONE;
                end else if (gap_l_r == {GAP_W{1'b0}}) begin
                    state_s = ST_PULSE;
                end else begin
                    state_s   = ST_GAP;
                    gap_cnt_s = gap_l_r;
                end
            end
            ST_GAP: begin
                // Leave on 1 so that a gap of g gives exactly g idle cycles.
                // Leaving on 0 as well guards against a corrupted counter.
                if (!window) begin
                    state_s = ST_ABORT;
                end else if (gap_cnt_r <= GAP_W'(1)) begin
                    state_s   = ST_PULSE;
                    gap_cnt_s = {GAP_W{1'b0}};
                end else begin
                    state_s   = ST_GAP;
                    gap_cnt_s = gap_cnt_r - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            ST_ABORT: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, req history and output flops.
    // Each output is loaded from a decode of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            req_q_r   <= 1'b0;
            gap_l_r   <= {GAP_W{1'b0}};
            gap_cnt_r <= {GAP_W{1'b0}};
            ack_cnt_r <= {CNT_W{1'b0}};
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            abort_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            req_q_r   <= req;
            gap_l_r   <= gap_l_s;
            gap_cnt_r <= gap_cnt_s;
            ack_cnt_r <= ack_cnt_s;
            ack_r     <= (state_s == ST_PULSE);
            busy_r    <= (state_s == ST_PULSE) || (state_s == ST_GAP);
            done_r    <= (state_s == ST_DONE);
            abort_r   <= (state_s == ST_ABORT);
        end
    end

endmodule
